mbist_test_sequencer: RTL and testbench

Host-side initiator for the MBIST BRAM shell. It drives the shell's test start-up enable (test_h), algorithm select and BIST reset, and consumes the shell's aggregated fail/done. On one start request it runs every algorithm enabled in a mask, one at a time. Before each algorithm it re-arms the shell with a reset pulse. It records a per-algorithm fail map and a per-algorithm timeout map, then reports overall pass/fail. It sits between the system/JTAG control logic and the BIST shell.

---
 rtl/mbist_test_sequencer.sv | 149 ++++++++++++++
 tb/tb_mbist_test_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_test_sequencer.sv
// MBIST host-side sequencer: walks an algorithm mask, re-arms the BRAM shell before
// each algorithm, runs it under a watchdog and collects per-algorithm fail/timeout maps.
module mbist_test_sequencer #(
   parameter int ALGNUM  = 3,
   parameter int RST_CYC = 4,
   parameter int TIMEOUT = 65536,
   parameter int CW      = 17
) (
   input  logic              bist_clk,
   input  logic              rst_l,
   input  logic              start,
   input  logic              abort,
   input  logic [ALGNUM:0]   alg_mask,
   input  logic              bist_fail,
   input  logic              bist_done,
   output logic              bist_rst_l,
   output logic              test_h,
   output logic [ALGNUM:0]   alg_sel,
   output logic              busy,
   output logic              seq_done,
   output logic              pass,
   output logic [ALGNUM:0]   fail_map,
   output logic [ALGNUM:0]   tmo_map,
   output logic              aborted
);

   localparam int IW = $clog2(ALGNUM + 2);
   localparam logic [IW-1:0]   IDX_END  = IW'(ALGNUM + 1);
   localparam logic [CW-1:0]   ARM_LAST = CW'(RST_CYC - 1);
   localparam logic [CW-1:0]   TMO_LAST = CW'(TIMEOUT - 1);
   localparam logic [ALGNUM:0] ONE      = (ALGNUM + 1)'(1);

   typedef enum logic [2:0] {IDLE, SCAN, ARM, RUN, GAP, FINISH} state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   idx, idx_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic [ALGNUM:0] mask, mask_nx;
   logic [ALGNUM:0] fail_nx, tmo_nx;
   logic            pass_nx, aborted_nx;
   logic [ALGNUM:0] mask_sh, onehot;

   // idx reaches ALGNUM+1 in SCAN, so select bits by shifting rather than indexing
   assign mask_sh = mask >> idx;
   assign onehot  = ONE << idx;

   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      cnt_nx     = cnt;
      mask_nx    = mask;
      fail_nx    = fail_map;
      tmo_nx     = tmo_map;
      pass_nx    = pass;
      aborted_nx = aborted;
      if (state != IDLE && abort) begin
         state_nx   = IDLE;
         aborted_nx = 1'b1;
         pass_nx    = 1'b0;
         cnt_nx     = '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mask_nx    = alg_mask;
                  fail_nx    = '0;
                  tmo_nx     = '0;
                  pass_nx    = 1'b0;
                  aborted_nx = 1'b0;
                  idx_nx     = '0;
                  cnt_nx     = '0;
                  state_nx   = SCAN;
               end
            end
            SCAN: begin
               if (idx == IDX_END) begin
                  state_nx = FINISH;
                  pass_nx  = ~|fail_map;
               end else if (mask_sh[0]) begin
                  state_nx = ARM;
                  cnt_nx   = '0;
               end else begin
                  idx_nx = idx + 1'b1;
               end
            end
            ARM: begin
               if (cnt == ARM_LAST) begin
                  state_nx = RUN;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            RUN: begin
               cnt_nx = cnt + 1'b1;
               // a done arriving on the last watchdog cycle still counts as a normal finish
               if (bist_done) begin
                  fail_nx  = bist_fail ? (fail_map | onehot) : fail_map;
                  state_nx = GAP;
               end else if (cnt == TMO_LAST) begin
                  fail_nx  = fail_map | onehot;
                  tmo_nx   = tmo_map | onehot;
                  state_nx = GAP;
               end
            end
            GAP: begin
               idx_nx   = idx + 1'b1;
               state_nx = SCAN;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they line up with the state register
   always_ff @(posedge bist_clk or negedge rst_l) begin
      if (!rst_l) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         mask       <= '0;
         fail_map   <= '0;
         tmo_map    <= '0;
         pass       <= 1'b0;
         aborted    <= 1'b0;
         bist_rst_l <= 1'b0;
         test_h     <= 1'b0;
         alg_sel    <= '0;
         busy       <= 1'b0;
         seq_done   <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         cnt        <= cnt_nx;
         mask       <= mask_nx;
         fail_map   <= fail_nx;
         tmo_map    <= tmo_nx;
         pass       <= pass_nx;
         aborted    <= aborted_nx;
         bist_rst_l <= (state_nx != ARM);
         test_h     <= (state_nx == RUN);
         alg_sel    <= (state_nx == RUN) ? onehot : '0;
         busy       <= (state_nx != IDLE);
         seq_done   <= (state_nx == FINISH);
      end
   end

endmodule

// File: tb/tb_mbist_test_sequencer.sv
// Directed bench for mbist_test_sequencer with a behavioural BIST shell responder.
module tb_mbist_test_sequencer;

   logic       clk = 1'b0;
   logic       rst_l;
   logic       start;
   logic       abort;
   logic [3:0] alg_mask;
   logic       bist_fail = 1'b0;
   logic       bist_done = 1'b0;
   logic       bist_rst_l, test_h, busy, seq_done, pass, aborted;
   logic [3:0] alg_sel, fail_map, tmo_map;

   int vectors = 0;
   int miscompares = 0;

   mbist_test_sequencer #(.ALGNUM(3), .RST_CYC(4), .TIMEOUT(32), .CW(17)) dut (
      .bist_clk(clk), .rst_l(rst_l), .start(start), .abort(abort), .alg_mask(alg_mask),
      .bist_fail(bist_fail), .bist_done(bist_done), .bist_rst_l(bist_rst_l), .test_h(test_h),
      .alg_sel(alg_sel), .busy(busy), .seq_done(seq_done), .pass(pass),
      .fail_map(fail_map), .tmo_map(tmo_map), .aborted(aborted)
   );

   always #5 clk = ~clk;

   // Shell responder: done after dly[a] cycles of test_h (0 = never), fail per fb[a]
   int dly [4];
   bit fb  [4];
   int hcnt = 0;
   always @(negedge clk) begin
      int a;
      a = 0;
      for (int i = 0; i < 4; i++) if (alg_sel[i]) a = i;
      if (test_h) hcnt++;
      else hcnt = 0;
      bist_done = test_h && (dly[a] != 0) && (hcnt == dly[a]);
      bist_fail = bist_done && fb[a];
   end

   // Activity monitor
   int sd_total = 0, th_total = 0, rst_pulses = 0, rst_bad = 0, rlen = 0, log_n = 0;
   logic [3:0] alg_log [32];
   logic [3:0] prev_sel = 4'b0;
   always @(negedge clk) begin
      if (seq_done) sd_total++;
      if (test_h) th_total++;
      if (busy && !bist_rst_l) rlen++;
      else if (rlen != 0) begin
         rst_pulses++;
         if (rlen != 4) rst_bad++;
         rlen = 0;
      end
      if (alg_sel != 4'b0 && prev_sel == 4'b0 && log_n < 32) begin
         alg_log[log_n] = alg_sel;
         log_n++;
      end
      prev_sel = alg_sel;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start with mask; report cycle of first test_h and of seq_done (-1 if none)
   task automatic run_seq(input logic [3:0] mask, output int th_k, output int done_k);
      int k;
      start = 1'b1;
      alg_mask = mask;
      step();
      start = 1'b0;
      th_k = -1;
      done_k = -1;
      k = 1;
      while (k < 600) begin
         if (test_h && th_k < 0) th_k = k;
         if (seq_done) begin
            done_k = k;
            break;
         end
         step();
         k++;
      end
      chk("seq_done_seen", 32'(done_k >= 0), 32'd1);
   endtask

   task automatic wait_sel(input logic [3:0] sel, input string tag);
      int k;
      k = 0;
      while (alg_sel !== sel && k < 300) begin
         step();
         k++;
      end
      chk(tag, 32'(alg_sel), 32'(sel));
   endtask

   initial begin
      int th_k, done_k, sd_b, th_b, rp_b, rb_b, lg_b;
      rst_l = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      alg_mask = 4'b0;
      for (int i = 0; i < 4; i++) begin
         dly[i] = 20;
         fb[i] = 1'b0;
      end
      step();
      step();
      chk("rst_bist_rst_l", 32'(bist_rst_l), 32'd0);
      chk("rst_test_h", 32'(test_h), 32'd0);
      chk("rst_alg_sel", 32'(alg_sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_seq_done", 32'(seq_done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_fail_map", 32'(fail_map), 32'd0);
      chk("rst_tmo_map", 32'(tmo_map), 32'd0);
      chk("rst_aborted", 32'(aborted), 32'd0);
      rst_l = 1'b1;
      step();
      chk("idle_bist_rst_l", 32'(bist_rst_l), 32'd1);
      step();

      // 1: mask 0101, algorithm 2 fails
      fb[2] = 1'b1;
      sd_b = sd_total; th_b = th_total; rp_b = rst_pulses; rb_b = rst_bad; lg_b = log_n;
      run_seq(4'b0101, th_k, done_k);
      chk("t1_first_test_h_cycle", 32'(th_k), 32'd6);
      chk("t1_seq_done_cycle", 32'(done_k), 32'd56);
      chk("t1_pass", 32'(pass), 32'd0);
      chk("t1_fail_map", 32'(fail_map), 32'h4);
      chk("t1_tmo_map", 32'(tmo_map), 32'h0);
      step();
      chk("t1_seq_done_count", 32'(sd_total - sd_b), 32'd1);
      chk("t1_test_h_cycles", 32'(th_total - th_b), 32'd40);
      chk("t1_rst_pulses", 32'(rst_pulses - rp_b), 32'd2);
      chk("t1_rst_pulse_len", 32'(rst_bad - rb_b), 32'd0);
      chk("t1_alg_count", 32'(log_n - lg_b), 32'd2);
      chk("t1_alg_first", 32'(alg_log[lg_b]), 32'h1);
      chk("t1_alg_second", 32'(alg_log[lg_b+1]), 32'h4);
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_maps_hold", 32'(fail_map), 32'h4);
      fb[2] = 1'b0;

      // 2: all four algorithms pass
      rp_b = rst_pulses; rb_b = rst_bad; lg_b = log_n;
      run_seq(4'b1111, th_k, done_k);
      chk("t2_pass", 32'(pass), 32'd1);
      chk("t2_fail_map", 32'(fail_map), 32'h0);
      chk("t2_alg_count", 32'(log_n - lg_b), 32'd4);
      chk("t2_alg_order", 32'({alg_log[lg_b], alg_log[lg_b+1], alg_log[lg_b+2], alg_log[lg_b+3]}), 32'h1248);
      chk("t2_rst_pulses", 32'(rst_pulses - rp_b), 32'd4);
      chk("t2_rst_pulse_len", 32'(rst_bad - rb_b), 32'd0);
      step();

      // 3: algorithm 1 hangs, watchdog fires
      dly[1] = 0;
      th_b = th_total;
      run_seq(4'b0010, th_k, done_k);
      chk("t3_fail_map", 32'(fail_map), 32'h2);
      chk("t3_tmo_map", 32'(tmo_map), 32'h2);
      chk("t3_pass", 32'(pass), 32'd0);
      step();
      chk("t3_test_h_cycles", 32'(th_total - th_b), 32'd32);

      // 4: done on the last watchdog cycle beats the timeout
      dly[1] = 32;
      th_b = th_total;
      run_seq(4'b0010, th_k, done_k);
      chk("t4_tmo_map", 32'(tmo_map), 32'h0);
      chk("t4_fail_map", 32'(fail_map), 32'h0);
      chk("t4_pass", 32'(pass), 32'd1);
      step();
      chk("t4_test_h_cycles", 32'(th_total - th_b), 32'd32);
      dly[1] = 20;

      // 5: empty mask
      th_b = th_total;
      run_seq(4'b0000, th_k, done_k);
      chk("t5_seq_done_cycle", 32'(done_k), 32'd6);
      chk("t5_pass", 32'(pass), 32'd1);
      chk("t5_fail_map", 32'(fail_map), 32'h0);
      chk("t5_test_h_never", 32'(th_total - th_b), 32'd0);
      step();

      // 6: abort during algorithm 2, extra start while busy
      fb[0] = 1'b1;
      sd_b = sd_total; lg_b = log_n;
      start = 1'b1;
      alg_mask = 4'b0111;
      step();
      start = 1'b0;
      wait_sel(4'b0010, "t6_reach_alg1");
      start = 1'b1;
      alg_mask = 4'b1111;
      step();
      start = 1'b0;
      alg_mask = 4'b0000;
      wait_sel(4'b0100, "t6_reach_alg2");
      repeat (5) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_test_h", 32'(test_h), 32'd0);
      chk("t6_alg_sel", 32'(alg_sel), 32'h0);
      chk("t6_aborted", 32'(aborted), 32'd1);
      chk("t6_pass", 32'(pass), 32'd0);
      chk("t6_fail_map_partial", 32'(fail_map), 32'h1);
      chk("t6_tmo_map", 32'(tmo_map), 32'h0);
      repeat (10) step();
      chk("t6_no_seq_done", 32'(sd_total - sd_b), 32'd0);
      chk("t6_aborted_hold", 32'(aborted), 32'd1);
      chk("t6_alg_count", 32'(log_n - lg_b), 32'd3);
      chk("t6_alg_order", 32'({alg_log[lg_b], alg_log[lg_b+1], alg_log[lg_b+2]}), 32'h124);
      fb[0] = 1'b0;
      start = 1'b1;
      alg_mask = 4'b0000;
      step();
      start = 1'b0;
      chk("t6_restart_aborted", 32'(aborted), 32'd0);
      chk("t6_restart_fail_map", 32'(fail_map), 32'h0);
      repeat (5) step();
      chk("t6_restart_seq_done", 32'(seq_done), 32'd1);
      chk("t6_restart_pass", 32'(pass), 32'd1);
      step();

      // 7: asynchronous reset mid-run
      dly[0] = 0;
      start = 1'b1;
      alg_mask = 4'b0001;
      step();
      start = 1'b0;
      wait_sel(4'b0001, "t7_reach_alg0");
      repeat (3) step();
      rst_l = 1'b0;
      #1;
      chk("t7_async_bist_rst_l", 32'(bist_rst_l), 32'd0);
      chk("t7_async_test_h", 32'(test_h), 32'd0);
      chk("t7_async_busy", 32'(busy), 32'd0);
      chk("t7_async_alg_sel", 32'(alg_sel), 32'h0);
      step();
      rst_l = 1'b1;
      step();
      chk("t7_idle_bist_rst_l", 32'(bist_rst_l), 32'd1);
      chk("t7_idle_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
